// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the nibble-serial CLA word sequencer.
package cla_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned NIBBLE_W = 4;

  // Two's-complement overflow: same-sign operands producing an opposite-sign result.
  function automatic logic signed_overflow(input logic a_msb, input logic b_msb,
                                           input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/lookaheadcarryadder.sv
// 4-bit carry-lookahead adder slice shared by the word sequencer.
module lookaheadcarryadder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum   = p ^ c[3:0];
  assign c_out = c[4];

endmodule

// File: rtl/cla_word_sequencer.sv
// WIDTH-bit add/subtract that walks one nibble per clock through a single 4-bit CLA slice.
module cla_word_sequencer
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned SH_W    = IDX_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  generate
    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
      $error("cla_word_sequencer: WIDTH must be a non-zero multiple of 4");
    end
  endgenerate

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] work;
  logic             carry;

  logic [SH_W-1:0]     shamt;
  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_c;
  logic [WIDTH-1:0]    nib_mask;
  logic [WIDTH-1:0]    work_next;

  // Nibble select: bit offset of the active nibble is idx*4.
  assign shamt   = {idx, 2'b00};
  assign slice_a = NIBBLE_W'(a_reg >> shamt);
  assign slice_b = NIBBLE_W'(b_reg >> shamt);

  lookaheadcarryadder u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry),
    .sum   (slice_sum),
    .c_out (slice_c)
  );

  // Working word with the current slice result merged into its nibble.
  always_comb begin
    nib_mask  = WIDTH'(4'hF) << shamt;
    work_next = (work & ~nib_mask) | (WIDTH'(slice_sum) << shamt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      work     <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b ^ {WIDTH{sub}};
            carry <= sub | c_in;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          work  <= work_next;
          carry <= slice_c;
          if (idx == LAST_IDX) begin
            sum      <= work_next;
            c_out    <= slice_c;
            overflow <= signed_overflow(a_reg[WIDTH-1], b_reg[WIDTH-1], work_next[WIDTH-1]);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Randomized self-checking bench for cla_word_sequencer against an arithmetic reference model.
module tb_cla_word_sequencer;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic         c_in  = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  cla_word_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Integer-arithmetic reference: returns {overflow, c_out, sum}.
  function automatic logic [W+1:0] ref_calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci, input logic s);
    int ux, uy, sx, sy, t, rs;
    logic [W-1:0] r;
    logic co, ov;
    ux = int'({16'h0, x});
    uy = int'({16'h0, y});
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      t  = ux - uy;
      co = (ux >= uy);
      rs = sx - sy;
    end else begin
      t  = ux + uy + int'({31'h0, ci});
      co = (t >= 65536);
      rs = sx + sy + int'({31'h0, ci});
    end
    r  = W'(t);
    ov = (rs > 32767) || (rs < -32768);
    return {ov, co, r};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Transaction-level model: result appears NIB edges after the accepting edge.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;
  logic [W-1:0] m_sum  = '0;
  logic [W+1:0] m_pend = '0;
  int           m_cnt  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
      m_sum  <= '0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_pend <= ref_calc(a, b, c_in, sub);
          m_cnt  <= NIB;
          m_busy <= 1'b1;
        end
      end else if (m_cnt == 1) begin
        {m_ovf, m_cout, m_sum} <= m_pend;
        m_done <= 1'b1;
        m_busy <= 1'b0;
        m_cnt  <= 0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("sum", 32'(sum), 32'(m_sum));
      check("c_out", 32'(c_out), 32'(m_cout));
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // Called just after a clock edge with the unit idle; returns just after the done edge.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xci,
                       input logic xs, input logic [W-1:0] es, input logic ec,
                       input logic eo, input string nm);
    int lat;
    logic [W+1:0] r;
    r = ref_calc(xa, xb, xci, xs);
    check({nm, "_model"}, 32'(r), 32'({eo, ec, es}));
    a = xa; b = xb; c_in = xci; sub = xs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_lat"}, 32'(lat), 32'(NIB));
    check({nm, "_sum"}, 32'(sum), 32'(es));
    check({nm, "_cout"}, 32'(c_out), 32'(ec));
    check({nm, "_ovf"}, 32'(overflow), 32'(eo));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    int lat;
    logic [W-1:0] got;
    logic [W-1:0] xa, xb;
    logic xci, xs;
    logic [W+1:0] r;

    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_sum", 32'(sum), 32'h0);
    check("rst_cout", 32'(c_out), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Consecutive calls issue the next start during the done cycle.
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_chain");
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    do_op(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0, "add_cin");
    do_op(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");

    // start held for four edges with changing operands: only the first is taken.
    dcount = 0;
    got = '0;
    a = 16'h0102; b = 16'h0304; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) begin dcount++; got = sum; end
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    end
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) begin dcount++; got = sum; end
    end
    check("hold_done_count", 32'(dcount), 32'd1);
    check("hold_sum", 32'(got), 32'h0406);

    // Reset two edges into a run aborts it.
    a = 16'hAAAA; b = 16'h5555; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_sum", 32'(sum), 32'h0);
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("midrst_no_done", 32'(dcount), 32'd0);
    do_op(16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, "post_rst");

    // Random sweep with noise on the inputs while busy and random idle gaps.
    for (int n = 0; n < 1000; n++) begin
      xa = pick(); xb = pick(); xci = 1'($urandom); xs = 1'($urandom);
      r = ref_calc(xa, xb, xci, xs);
      a = xa; b = xb; c_in = xci; sub = xs; start = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (!done && lat < 20) begin
        start = 1'($urandom);
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
        @(posedge clk); #1;
        lat++;
      end
      start = 1'b0;
      check("rand_lat", 32'(lat), 32'(NIB));
      check("rand_result", 32'({overflow, c_out, sum}), 32'(r));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
